ram_word_sequencer: RTL and testbench



---
 rtl/ram_word_sequencer.sv | 104 ++++++++++
 tb/tb_ram_word_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_word_sequencer.sv
// rtl/ram_word_sequencer.sv - operand RAM that scans words 0..last with a programmable dwell per word
module ram_word_sequencer #(
  parameter int n     = 6,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [n-1:0]  wr_data,
  input  logic          start,
  input  logic [AW-1:0] last,
  input  logic [DW-1:0] dwell,
  output logic [n-1:0]  ram_out,
  output logic          counter_done,
  output logic [AW-1:0] ram_addr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    HOLD,
    EMIT,
    FINISH
  } state_t;

  state_t        state;
  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] last_q;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] cnt;

  // Writes are only taken while idle so a running scan never sees a changing word.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ram_out      <= '0;
      ram_addr     <= '0;
      cnt          <= '0;
      last_q       <= '0;
      dwell_q      <= '0;
      counter_done <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      counter_done <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            ram_addr <= '0;
            last_q   <= last;
            dwell_q  <= dwell;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        READ: begin
          ram_out <= mem[ram_addr];
          cnt     <= '0;
          state   <= HOLD;
        end
        HOLD: begin
          // Strobe is registered, so it is raised on the same edge that enters EMIT.
          if (cnt == dwell_q) begin
            state        <= EMIT;
            counter_done <= 1'b1;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        EMIT: begin
          if (ram_addr == last_q) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            ram_addr <= ram_addr + AW'(1);
            state    <= READ;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_sequencer.sv
// tb/tb_ram_word_sequencer.sv - directed self-checking bench for ram_word_sequencer
module tb_ram_word_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       start = 1'b0;
  logic [3:0] last = '0;
  logic [7:0] dwell = '0;
  logic [5:0] ram_out;
  logic       counter_done;
  logic [3:0] ram_addr;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  logic [5:0] sval[$];
  logic [3:0] saddr[$];
  int         scyc[$];
  logic [5:0] rout[$];
  int         busy_cnt;
  int         done_cyc;
  int         done_cnt;
  int         consec;

  ram_word_sequencer #(.n(6), .DEPTH(16), .AW(4), .DW(8)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .last(last),
    .dwell(dwell),
    .ram_out(ram_out),
    .counter_done(counter_done),
    .ram_addr(ram_addr),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Cycle c = 0 is the cycle right after the edge that accepts start.
  task automatic scan(input logic [3:0] l, input logic [7:0] d, input int inj_c,
                      input bit inj_wr, input int rst_c, input bit wr0);
    int c;
    bit prev_cd;
    sval.delete();
    saddr.delete();
    scyc.delete();
    rout.delete();
    busy_cnt = 0;
    done_cyc = -1;
    done_cnt = 0;
    consec = 0;
    prev_cd = 1'b0;
    last = l;
    dwell = d;
    start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1;
      wr_addr = 4'd0;
      wr_data = 6'h1C;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (c = 0; c < 3000; c++) begin
      if (!busy) break;
      busy_cnt++;
      rout.push_back(ram_out);
      if (counter_done) begin
        sval.push_back(ram_out);
        saddr.push_back(ram_addr);
        scyc.push_back(c);
        if (prev_cd) consec++;
      end
      prev_cd = counter_done;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {ram_out, ram_addr, counter_done, busy, done}, 32'd0);
        tick();
        rst = 1'b0;
        break;
      end
      if (c == inj_c) begin
        start = 1'b1;
        if (inj_wr) begin
          wr_en = 1'b1;
          wr_addr = 4'd2;
          wr_data = 6'h00;
        end
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
    end
    chk("scan_timeout", (c >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    logic [5:0] exp1[4] = '{6'h05, 6'h11, 6'h2A, 6'h3F};
    int quiet;

    tick();
    tick();
    chk("reset_outputs", {ram_out, ram_addr, counter_done, busy, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Four words, dwell 0: strobes every 3 cycles.
    for (int i = 0; i < 4; i++) wr(4'(i), exp1[i]);
    scan(4'd3, 8'd0, -1, 1'b0, -1, 1'b0);
    chk("t1_count", sval.size(), 4);
    for (int i = 0; i < sval.size() && i < 4; i++) begin
      chk("t1_val", sval[i], exp1[i]);
      chk("t1_addr", saddr[i], i);
      chk("t1_cyc", scyc[i], 2 + 3 * i);
    end
    chk("t1_done_cyc", done_cyc, 12);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy", busy_cnt, 13);

    // Single word, dwell 5: word stays put across all hold cycles.
    wr(4'd0, 6'h21);
    scan(4'd0, 8'd5, -1, 1'b0, -1, 1'b0);
    chk("t2_count", sval.size(), 1);
    if (sval.size() > 0) begin
      chk("t2_val", sval[0], 6'h21);
      chk("t2_cyc", scyc[0], 7);
    end
    for (int c = 1; c <= 7 && c < rout.size(); c++) chk("t2_stable", rout[c], 6'h21);
    chk("t2_done_cyc", done_cyc, 8);
    chk("t2_busy", busy_cnt, 9);

    // Full scan, dwell 1: no address wrap past 15.
    for (int i = 0; i < 16; i++) wr(4'(i), 6'(i));
    scan(4'd15, 8'd1, -1, 1'b0, -1, 1'b0);
    chk("t3_count", sval.size(), 16);
    for (int i = 0; i < sval.size() && i < 16; i++) begin
      chk("t3_val", sval[i], i);
      chk("t3_cyc", scyc[i], 3 + 4 * i);
    end
    chk("t3_consec", consec, 0);
    chk("t3_busy", busy_cnt, 65);
    chk("t3_done_cyc", done_cyc, 64);
    chk("t3_end_addr", ram_addr, 4'd15);

    // start and wr_en while busy are dropped.
    scan(4'd3, 8'd0, 4, 1'b1, -1, 1'b0);
    chk("t4_count", sval.size(), 4);
    chk("t4_busy", busy_cnt, 13);
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) quiet++;
      tick();
    end
    chk("t4_no_restart", quiet, 0);
    scan(4'd3, 8'd0, -1, 1'b0, -1, 1'b0);
    chk("t4_mem2_kept", (sval.size() > 2) ? 32'(sval[2]) : 32'hFFFF, 32'd2);

    // start in the FINISH cycle is ignored.
    scan(4'd0, 8'd0, 3, 1'b0, -1, 1'b0);
    chk("t4b_done_cyc", done_cyc, 3);
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) quiet++;
      tick();
    end
    chk("t4b_finish_start", quiet, 0);

    // Reset during HOLD of word 2 aborts the scan.
    scan(4'd3, 8'd4, -1, 1'b0, 16, 1'b0);
    chk("t5_pre_strobes", sval.size(), 2);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      if (counter_done || done || busy) quiet++;
      tick();
    end
    chk("t5_quiet", quiet, 0);
    scan(4'd3, 8'd0, -1, 1'b0, -1, 1'b0);
    chk("t5_count", sval.size(), 4);
    for (int i = 0; i < sval.size() && i < 4; i++) chk("t5_val", sval[i], i);

    // Same-cycle start and write to address 0.
    scan(4'd1, 8'd0, -1, 1'b0, -1, 1'b1);
    chk("t6_count", sval.size(), 2);
    if (sval.size() > 1) begin
      chk("t6_first", sval[0], 6'h1C);
      chk("t6_second", sval[1], 6'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
